// File: rtl/aqua_pkg.sv
// Shared types and default latencies for the dual-issue hazard scoreboard.
// Optional performance counters in the top are enabled with SCB_PERF_CNT_EN.
package aqua_pkg;

    // Execution unit that will produce an instruction's result.
    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_BRU = 2'd1,
        UNIT_MEM = 2'd2
    } unit_t;

    // One issue candidate as seen by the scoreboard.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr_en;
        unit_t      unit;
    } issue_req_t;

    // Default cycles from issue until a result becomes forwardable.
    localparam int ALU_LAT = 0;
    localparam int BRU_LAT = 0;
    localparam int MEM_LAT = 1;

    // BRU and MEM share the V-pipe resources, so only one of them may issue per pair.
    function automatic logic is_bru_or_mem(input unit_t u);
        return (u == UNIT_BRU) || (u == UNIT_MEM);
    endfunction

endpackage

// File: rtl/scb_hazard_check.sv
// Per-instruction readiness check against the scoreboard countdowns:
// both sources forwardable and no WAW against a slower in-flight writer.
module scb_hazard_check #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int ALU_LAT  = aqua_pkg::ALU_LAT,
    parameter int BRU_LAT  = aqua_pkg::BRU_LAT,
    parameter int MEM_LAT  = aqua_pkg::MEM_LAT
) (
    input  aqua_pkg::issue_req_t          i_req,
    input  logic [NUM_REGS*CNT_W-1:0]     i_cnt,
    output logic                          o_ok,
    output logic [CNT_W-1:0]              o_lat
);
    import aqua_pkg::*;

    logic w_rs1_rdy;
    logic w_rs2_rdy;
    logic w_waw_ok;

    // x0 and out-of-range addresses are never tracked and always read as ready.
    function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] addr,
                                                 input logic [NUM_REGS*CNT_W-1:0] flat);
        if ((int'(addr) == 0) || (int'(addr) >= NUM_REGS)) begin
            return {CNT_W{1'b0}};
        end else begin
            return flat[int'(addr)*CNT_W +: CNT_W];
        end
    endfunction

    // Latency of the unit this instruction targets; unknown codes take the slowest path.
    always_comb begin
        o_lat = CNT_W'(MEM_LAT);
        case (i_req.unit)
            UNIT_ALU: o_lat = CNT_W'(ALU_LAT);
            UNIT_BRU: o_lat = CNT_W'(BRU_LAT);
            UNIT_MEM: o_lat = CNT_W'(MEM_LAT);
            default:  o_lat = CNT_W'(MEM_LAT);
        endcase
    end

    // Sources must be ready; a new write must not complete before an older one to the same rd.
    always_comb begin
        w_rs1_rdy = (cnt_of(i_req.rs1, i_cnt) == {CNT_W{1'b0}});
        w_rs2_rdy = (cnt_of(i_req.rs2, i_cnt) == {CNT_W{1'b0}});
        if (i_req.wr_en && (i_req.rd != 5'd0)) begin
            w_waw_ok = (cnt_of(i_req.rd, i_cnt) <= o_lat);
        end else begin
            w_waw_ok = 1'b1;
        end
        o_ok = i_req.valid & w_rs1_rdy & w_rs2_rdy & w_waw_ok;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue hazard scheduler between decode and the U/V pipes.
// Keeps a per-register countdown until each in-flight result is forwardable and
// grants instr1/instr2 in order. Define SCB_PERF_CNT_EN to add stall/dual-issue counters.
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ALU_LAT  = aqua_pkg::ALU_LAT,
    parameter int BRU_LAT  = aqua_pkg::BRU_LAT,
    parameter int MEM_LAT  = aqua_pkg::MEM_LAT,
    parameter int CNT_W    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid_instr1,
    input  logic        i_valid_instr2,
    input  logic [4:0]  i_rs1_instr1,
    input  logic [4:0]  i_rs2_instr1,
    input  logic [4:0]  i_rd_instr1,
    input  logic [4:0]  i_rs1_instr2,
    input  logic [4:0]  i_rs2_instr2,
    input  logic [4:0]  i_rd_instr2,
    input  logic        i_wr_en_instr1,
    input  logic        i_wr_en_instr2,
    input  logic [1:0]  i_unit_instr1,
    input  logic [1:0]  i_unit_instr2,
    input  logic        i_ex_stall,
    input  logic        i_flush,
    output logic        o_issue_instr1,
    output logic        o_issue_instr2,
    output logic        o_stall
`ifdef SCB_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_dual_issues
`endif
);
    import aqua_pkg::*;

    logic [CNT_W-1:0]          r_cnt [NUM_REGS];
    logic [NUM_REGS*CNT_W-1:0] w_cnt_flat;
    issue_req_t                w_req1;
    issue_req_t                w_req2;
    logic                      w_ok1;
    logic                      w_ok2;
    logic [CNT_W-1:0]          w_lat1;
    logic [CNT_W-1:0]          w_lat2;
    logic                      w_pair_raw;
    logic                      w_pair_waw;
    logic                      w_pair_struct;
    logic                      w_grant1;
    logic                      w_grant2;

    assign w_req1 = '{valid: i_valid_instr1, rs1: i_rs1_instr1, rs2: i_rs2_instr1,
                      rd: i_rd_instr1, wr_en: i_wr_en_instr1, unit: unit_t'(i_unit_instr1)};
    assign w_req2 = '{valid: i_valid_instr2, rs1: i_rs1_instr2, rs2: i_rs2_instr2,
                      rd: i_rd_instr2, wr_en: i_wr_en_instr2, unit: unit_t'(i_unit_instr2)};

    // Present the countdown array to the hazard checkers as one flat vector.
    always_comb begin
        w_cnt_flat = {(NUM_REGS*CNT_W){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_flat[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    scb_hazard_check #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .ALU_LAT  (ALU_LAT),
        .BRU_LAT  (BRU_LAT),
        .MEM_LAT  (MEM_LAT)
    ) u_check1 (
        .i_req (w_req1),
        .i_cnt (w_cnt_flat),
        .o_ok  (w_ok1),
        .o_lat (w_lat1)
    );

    scb_hazard_check #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .ALU_LAT  (ALU_LAT),
        .BRU_LAT  (BRU_LAT),
        .MEM_LAT  (MEM_LAT)
    ) u_check2 (
        .i_req (w_req2),
        .i_cnt (w_cnt_flat),
        .o_ok  (w_ok2),
        .o_lat (w_lat2)
    );

    // Grant logic: instr2 rides on instr1 and must not depend on or collide with it.
    always_comb begin
        w_pair_raw    = i_wr_en_instr1 && (i_rd_instr1 != 5'd0) &&
                        ((i_rd_instr1 == i_rs1_instr2) || (i_rd_instr1 == i_rs2_instr2));
        w_pair_waw    = i_wr_en_instr1 && i_wr_en_instr2 && (i_rd_instr1 != 5'd0) &&
                        (i_rd_instr1 == i_rd_instr2);
        w_pair_struct = is_bru_or_mem(w_req1.unit) && is_bru_or_mem(w_req2.unit);
        w_grant1      = i_rst_n & ~i_ex_stall & ~i_flush & w_ok1;
        w_grant2      = w_grant1 & w_ok2 & ~w_pair_raw & ~w_pair_waw & ~w_pair_struct;
        o_issue_instr1 = w_grant1;
        o_issue_instr2 = w_grant2;
        o_stall        = i_rst_n & i_valid_instr1 & ~w_grant1 & ~i_flush;
    end

    // Countdown update: decrement in-flight entries, newly issued writers load their latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (!i_ex_stall) begin
            r_cnt[0] <= {CNT_W{1'b0}};
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_grant1 && i_wr_en_instr1 && (int'(i_rd_instr1) == i)) begin
                    r_cnt[i] <= w_lat1;
                end else if (w_grant2 && i_wr_en_instr2 && (int'(i_rd_instr2) == i)) begin
                    r_cnt[i] <= w_lat2;
                end else if (r_cnt[i] != {CNT_W{1'b0}}) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= r_cnt[i];
            end
        end
    end

`ifdef SCB_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_dual_issues;

    // Saturating counters of stalled cycles and dual-issue cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= 32'd0;
            r_dual_issues  <= 32'd0;
        end else begin
            if (o_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (w_grant2 && (r_dual_issues != 32'hFFFF_FFFF)) begin
                r_dual_issues <= r_dual_issues + 32'd1;
            end else begin
                r_dual_issues <= r_dual_issues;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_dual_issues  = r_dual_issues;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios with literal
// expectations, then randomized traffic compared against a countdown model.
module tb_issue_scoreboard;

    localparam int LAT_ALU = 0;
    localparam int LAT_BRU = 0;
    localparam int LAT_MEM = 1;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid_instr1, i_valid_instr2;
    logic [4:0] i_rs1_instr1, i_rs2_instr1, i_rd_instr1;
    logic [4:0] i_rs1_instr2, i_rs2_instr2, i_rd_instr2;
    logic       i_wr_en_instr1, i_wr_en_instr2;
    logic [1:0] i_unit_instr1, i_unit_instr2;
    logic       i_ex_stall, i_flush;
    logic       o_issue_instr1, o_issue_instr2, o_stall;

    int n_checks = 0;
    int n_errors = 0;
    int mcnt [32];
    bit last1, last2, lasts;

    issue_scoreboard dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid_instr1 (i_valid_instr1),
        .i_valid_instr2 (i_valid_instr2),
        .i_rs1_instr1   (i_rs1_instr1),
        .i_rs2_instr1   (i_rs2_instr1),
        .i_rd_instr1    (i_rd_instr1),
        .i_rs1_instr2   (i_rs1_instr2),
        .i_rs2_instr2   (i_rs2_instr2),
        .i_rd_instr2    (i_rd_instr2),
        .i_wr_en_instr1 (i_wr_en_instr1),
        .i_wr_en_instr2 (i_wr_en_instr2),
        .i_unit_instr1  (i_unit_instr1),
        .i_unit_instr2  (i_unit_instr2),
        .i_ex_stall     (i_ex_stall),
        .i_flush        (i_flush),
        .o_issue_instr1 (o_issue_instr1),
        .o_issue_instr2 (o_issue_instr2),
        .o_stall        (o_stall)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int lat(input int u);
        if (u == 0) return LAT_ALU;
        if (u == 1) return LAT_BRU;
        return LAT_MEM;
    endfunction

    function automatic bit rdy(input int a);
        return (a == 0) || (mcnt[a] == 0);
    endfunction

    function automatic bit own_ok(input bit v, input int rs1, input int rs2, input int rd,
                                  input bit w, input int u);
        bit waw_ok;
        waw_ok = !(w && rd != 0) || (mcnt[rd] <= lat(u));
        return v && rdy(rs1) && rdy(rs2) && waw_ok;
    endfunction

    task automatic model(output bit g1, output bit g2, output bit s);
        bit raw, waw, strc;
        g1 = i_rst_n && !i_ex_stall && !i_flush &&
             own_ok(i_valid_instr1, i_rs1_instr1, i_rs2_instr1, i_rd_instr1, i_wr_en_instr1, i_unit_instr1);
        raw  = i_wr_en_instr1 && i_rd_instr1 != 0 &&
               (i_rd_instr1 == i_rs1_instr2 || i_rd_instr1 == i_rs2_instr2);
        waw  = i_wr_en_instr1 && i_wr_en_instr2 && i_rd_instr1 != 0 && i_rd_instr1 == i_rd_instr2;
        strc = (i_unit_instr1 == 1 || i_unit_instr1 == 2) && (i_unit_instr2 == 1 || i_unit_instr2 == 2);
        g2 = g1 && !raw && !waw && !strc &&
             own_ok(i_valid_instr2, i_rs1_instr2, i_rs2_instr2, i_rd_instr2, i_wr_en_instr2, i_unit_instr2);
        s  = i_rst_n && i_valid_instr1 && !g1 && !i_flush;
    endtask

    task automatic model_update(input bit g1, input bit g2);
        if (!i_ex_stall) begin
            for (int a = 1; a < 32; a++) if (mcnt[a] > 0) mcnt[a]--;
            if (g1 && i_wr_en_instr1 && i_rd_instr1 != 0) mcnt[i_rd_instr1] = lat(i_unit_instr1);
            if (g2 && i_wr_en_instr2 && i_rd_instr2 != 0) mcnt[i_rd_instr2] = lat(i_unit_instr2);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set1(input bit v, input int rs1, input int rs2, input int rd, input bit w, input int u);
        i_valid_instr1 = v; i_rs1_instr1 = 5'(rs1); i_rs2_instr1 = 5'(rs2);
        i_rd_instr1 = 5'(rd); i_wr_en_instr1 = w; i_unit_instr1 = 2'(u);
    endtask

    task automatic set2(input bit v, input int rs1, input int rs2, input int rd, input bit w, input int u);
        i_valid_instr2 = v; i_rs1_instr2 = 5'(rs1); i_rs2_instr2 = 5'(rs2);
        i_rd_instr2 = 5'(rd); i_wr_en_instr2 = w; i_unit_instr2 = 2'(u);
    endtask

    task automatic ctl(input bit st, input bit fl);
        i_ex_stall = st; i_flush = fl;
    endtask

    // Compare outputs against the model mid-cycle, then advance one clock.
    task automatic step(input string tag);
        bit g1, g2, s;
        model(g1, g2, s);
        #1;
        last1 = o_issue_instr1; last2 = o_issue_instr2; lasts = o_stall;
        check({tag, "_issue1"}, int'(o_issue_instr1), int'(g1));
        check({tag, "_issue2"}, int'(o_issue_instr2), int'(g2));
        check({tag, "_stall"},  int'(o_stall),        int'(s));
        @(posedge i_clk);
        model_update(g1, g2);
        #2;
    endtask

    task automatic idle(input int n);
        set1(0, 0, 0, 0, 0, 0); set2(0, 0, 0, 0, 0, 0); ctl(0, 0);
        for (int k = 0; k < n; k++) step("idle");
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mcnt[a] = 0;
        i_rst_n = 1'b0;
        set1(1, 1, 2, 3, 1, 0); set2(1, 4, 5, 6, 1, 0); ctl(0, 0);
        #2;
        check("reset_issue1", int'(o_issue_instr1), 0);
        check("reset_issue2", int'(o_issue_instr2), 0);
        check("reset_stall",  int'(o_stall),        0);
        #10;
        i_rst_n = 1'b1;
        #1;
        idle(2);

        // Load-use
        set1(1, 0, 0, 5, 1, 2); set2(0, 0, 0, 0, 0, 0);
        step("lu_load");  check("lu_load_pin", int'(last1), 1);
        set1(1, 5, 0, 6, 1, 0);
        step("lu_use0");  check("lu_use0_pin", int'(last1), 0); check("lu_use0_stall_pin", int'(lasts), 1);
        step("lu_use1");  check("lu_use1_pin", int'(last1), 1);

        // Intra-pair RAW
        idle(1);
        set1(1, 0, 0, 3, 1, 0); set2(1, 3, 0, 10, 1, 0);
        step("raw");      check("raw_pin1", int'(last1), 1); check("raw_pin2", int'(last2), 0);
        set2(1, 4, 0, 10, 1, 0);
        step("noraw");    check("noraw_pin2", int'(last2), 1);

        // Structural and x0
        set1(1, 12, 0, 11, 1, 1); set2(1, 14, 0, 13, 1, 2);
        step("struct");   check("struct_pin1", int'(last1), 1); check("struct_pin2", int'(last2), 0);
        set1(1, 0, 0, 0, 1, 2); set2(1, 0, 0, 0, 1, 0);
        step("x0");       check("x0_pin2", int'(last2), 1);

        // WAW
        idle(1);
        set1(1, 0, 0, 7, 1, 2); set2(0, 0, 0, 0, 0, 0);
        step("waw_load");
        set1(1, 0, 0, 7, 1, 0);
        step("waw_hold"); check("waw_hold_pin", int'(last1), 0);
        step("waw_go");   check("waw_go_pin", int'(last1), 1);
        set1(1, 0, 0, 9, 1, 0); set2(1, 0, 0, 9, 1, 0);
        step("waw_pair"); check("waw_pair_pin", int'(last2), 0);

        // Backend stall holds counters
        idle(1);
        set1(1, 0, 0, 5, 1, 2); set2(0, 0, 0, 0, 0, 0);
        step("st_load");
        set1(1, 5, 0, 8, 1, 0); ctl(1, 0);
        for (int k = 0; k < 3; k++) begin
            step("st_hold"); check("st_hold_pin", int'(last1), 0);
        end
        ctl(0, 0);
        step("st_after"); check("st_after_pin", int'(last1), 0);
        step("st_go");    check("st_go_pin", int'(last1), 1);

        // Flush suppresses grants but counters keep running
        idle(1);
        set1(1, 0, 0, 5, 1, 2);
        step("fl_load");
        set1(1, 5, 0, 8, 1, 0); set2(1, 0, 0, 12, 1, 0); ctl(0, 1);
        step("fl_kill");  check("fl_kill_pin", int'(last1), 0); check("fl_kill_stall_pin", int'(lasts), 0);
        ctl(0, 0);
        step("fl_go");    check("fl_go_pin", int'(last1), 1);

        // Asynchronous reset mid-cycle
        idle(1);
        set1(1, 0, 0, 5, 1, 2);
        step("ar_load");
        set1(1, 5, 0, 8, 1, 0);
        i_rst_n = 1'b0;
        #1;
        check("ar_issue1", int'(o_issue_instr1), 0);
        check("ar_stall",  int'(o_stall),        0);
        for (int a = 0; a < 32; a++) mcnt[a] = 0;
        #1;
        i_rst_n = 1'b1;
        step("ar_rel");   check("ar_rel_pin", int'(last1), 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set1($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2));
            set2($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2));
            ctl($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Dual-issue hazard scheduler that sits between the scheduler/decode stage and the U/V execution pipes.
- Tracks, per architectural register, how many cycles remain until an in-flight result becomes forwardable from the ALU/BRU/MEM result buffers.
- Grants issue to instr1 (U-pipe) and instr2 (V-pipe) only when every source can be supplied by the forwarding network or the register file.
- Blocks on RAW, WAW and structural conflicts, in order: instr2 never issues without instr1.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- ALU_LAT, 0, cycles after issue before an ALU result is forwardable (0 = back-to-back).
- BRU_LAT, 0, same for the V-pipe ALU/BRU.
- MEM_LAT, 1, same for the cache pipe (load-use bubble count); maximum 3.
- CNT_W, 2, countdown width; must satisfy 2^CNT_W > max(ALU_LAT, BRU_LAT, MEM_LAT).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid_instr1 / i_valid_instr2  in  1 each  candidate present.
- i_rs1_instr1, i_rs2_instr1, i_rd_instr1  in  5 each  register addresses.
- i_rs1_instr2, i_rs2_instr2, i_rd_instr2  in  5 each  register addresses.
- i_wr_en_instr1 / i_wr_en_instr2  in  1 each  writes rd.
- i_unit_instr1 / i_unit_instr2  in  2 each  unit_t: ALU=0, BRU=1, MEM=2.
- i_ex_stall  in  1  backend stall.
- i_flush  in  1  kill front-end candidates.
- o_issue_instr1 / o_issue_instr2  out  1 each  grant this cycle.
- o_stall  out  1  instr1 valid but not granted.

Behaviour:
- State: cnt[1..NUM_REGS-1], CNT_W bits each. cnt==0 means ready.
- Reset: all cnt=0. Outputs are combinational from state and inputs, so all are 0 while reset is asserted.
- Readiness: a source is ready if its address is 0 or cnt[addr]==0.
- lat(u): ALU→ALU_LAT, BRU→BRU_LAT, MEM→MEM_LAT.
- instr1 grant requires all of:
  - valid, !i_ex_stall, !i_flush;
  - rs1 and rs2 ready;
  - no WAW: if wr_en && rd!=0, then cnt[rd] <= lat(unit1).
- instr2 grant requires all of:
  - instr1 granted;
  - instr2 valid;
  - its own readiness and WAW rules;
  - no intra-pair RAW: instr1 wr_en && rd1!=0 && (rd1==rs1_2 || rd1==rs2_2);
  - no intra-pair WAW: both wr_en && rd1==rd2 && rd1!=0;
  - no structural conflict: not both units in {BRU, MEM}.
- o_stall = i_valid_instr1 & !o_issue_instr1 & !i_flush.
- Update every cycle when !i_ex_stall:
  - each nonzero cnt decrements by 1;
  - then, for each granted instr with wr_en && rd!=0, cnt[rd]=lat(unit). The new value overrides the decrement on the same register.
- Update when i_ex_stall=1: all cnt hold and no grants are issued.
- i_flush: suppresses grants only. Already-issued (older) instructions keep their counters.
- Writes to x0 are ignored. cnt never underflows and never exceeds MEM_LAT.
- Reset asserted mid-operation: cnt clears asynchronously, with no grants until release.

Optional Feature:
- Macro SCB_PERF_CNT_EN.
- When defined:
  - adds output o_stall_cycles (32 bits), counting cycles with o_stall=1;
  - adds output o_dual_issues (32 bits), counting cycles with both grants;
  - both reset to 0 and saturate at all-ones.
- When undefined: the ports and counters do not exist. Grant behaviour is identical either way.

Decomposition:
- aqua_pkg holds:
  - typedef unit_t (enum logic [1:0]);
  - typedef issue_req_t (valid, rs1, rs2, rd, wr_en, unit);
  - localparams ALU_LAT, BRU_LAT, MEM_LAT as defaults.
- One sub-module, scb_hazard_check: combinational per-instruction readiness/WAW check against the cnt array, instantiated twice.

Test Plan:
- Load-use: cycle0 instr1 = MEM load x5 granted; cycle1 instr1 = ALU add with rs1=x5 → o_issue_instr1=0, o_stall=1, then cnt[5] reaches 0 → cycle2 granted.
- Intra-pair RAW: instr1 = ALU writing x3, instr2 = ALU reading x3 → o_issue_instr1=1, o_issue_instr2=0. The same pair with instr2 reading x4 → both 1.
- Structural and x0: instr1=BRU, instr2=MEM, no register overlap → instr2 held. Any pair with rd=x0 or rs=x0 never creates a hazard.
- WAW: load x7 issued (cnt[7]=1), next cycle ALU write x7 → held one cycle. Intra-pair rd1=rd2=x9 → instr2 held.
- Stall/flush: after a load to x5, assert i_ex_stall for 3 cycles → cnt[5] stays 1 and no grants. Assert i_flush with valid candidates → grants 0, o_stall=0, counters keep decrementing.
- Async reset: assert i_rst_n=0 between clock edges with cnt[5]=1 → cnt clears immediately. After release, a reader of x5 is granted in the first cycle.
